// File: rtl/if_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package if_pkg;

  localparam int PC_W    = 22;
  localparam int INSTR_W = 32;

  // All-zero word is the pipeline NOP presented when nothing is fetched.
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Fetch queue: small synchronous FIFO of {pc, instr} entries.
// The head is read combinationally from storage. A push into an empty queue
// is visible one cycle later (no bypass). Flush empties the queue immediately
// and takes priority over push/pop in the same cycle.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fq_entry_t        push_data,
  input  logic             pop,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, issues word requests to
// instruction memory under a credit limit (outstanding + queued <= FQ_DEPTH),
// buffers in-order responses in the fetch queue and presents the head to IF/ID.
// A redirect flushes the queue and discards responses still in flight.
//
// Handshakes: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; imem_req_valid only drops without a transfer
// because of redirect or hlt. Responses are never refused (no rsp ready).
//
// Optional feature: define IF_PERF_CNT_EN to add the saturating
// perf_fetched / perf_bubble counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               hlt,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic [INSTR_W-1:0] IF_instr,
  output logic [PC_W-1:0]    IF_PC,
  output logic               IF_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubble
`endif
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  rsp_pc;
  logic [CNT_W-1:0] outst;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fq_count;
  logic [CNT_W:0]   credit_used;
  logic             has_credit;
  logic             req_fire;
  logic             drop_now;
  logic             fq_push;
  logic             fq_pop;
  fq_entry_t        fq_in;
  fq_entry_t        fq_head;

  // Credit check, request, enqueue and dequeue decisions; redirect overrides all of them.
  always_comb begin
    credit_used    = {1'b0, outst} + {1'b0, fq_count};
    has_credit     = credit_used < (CNT_W + 1)'(FQ_DEPTH);
    imem_req_valid = rst_n & ~hlt & ~redirect & has_credit;
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid & imem_req_ready;
    drop_now       = imem_rsp_valid & (drop_cnt != '0);
    fq_push        = imem_rsp_valid & ~redirect & (drop_cnt == '0);
    IF_valid       = (fq_count != '0);
    fq_pop         = IF_valid & ~stall & ~hlt & ~redirect;
    fq_in.pc       = rsp_pc;
    fq_in.instr    = imem_rsp_data;
    IF_instr       = IF_valid ? fq_head.instr : NOP_INSTR;
    IF_PC          = IF_valid ? fq_head.pc : '0;
  end

  // Fetch/response PCs, outstanding-request count and wrong-path drop count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      // Everything still in flight is wrong-path; the response arriving now is dropped on the spot.
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      outst    <= outst - CNT_W'(imem_rsp_valid);
      drop_cnt <= outst - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_W'(1);
      if (fq_push)  rsp_pc   <= rsp_pc + PC_W'(1);
      if (drop_now) drop_cnt <= drop_cnt - CNT_W'(1);
      outst <= outst + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    end
  end

  if_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (fq_push),
    .push_data (fq_in),
    .pop       (fq_pop),
    .head      (fq_head),
    .count     (fq_count)
  );

`ifdef IF_PERF_CNT_EN
  // Saturating counters of delivered instructions and of non-halted empty cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubble  <= '0;
    end else begin
      if (fq_pop && (perf_fetched != '1))          perf_fetched <= perf_fetched + 32'd1;
      if (!IF_valid && !hlt && (perf_bubble != '1)) perf_bubble  <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule
